// File: rtl/freq_div_pkg.sv
// Shared defaults and FSM state encoding for the frequency-to-divider scheduler.
package freq_div_pkg;
    localparam int NCH_DEF      = 4;
    localparam int W_DEF        = 26;
    localparam int CLK_HALF_DEF = 25000000;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;
endpackage

// File: rtl/freq_div_sched_div_iter.sv
// Unsigned restoring divider, one quotient bit per cycle, W cycles per division.
module div_iter
    import freq_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;

    logic [W:0]    shifted;
    logic [W:0]    diff;
    logic          fits;

    // Shift the next dividend bit into the partial remainder and try a subtraction.
    assign shifted = {rem_q, quo_q[W-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign fits    = (shifted >= {1'b0, dvs_q});

    assign quotient = quo_q;
    assign done     = run_q && (cnt_q == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= CW'(W - 1);
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? diff[W-1:0] : shifted[W-1:0];
            quo_q <= {quo_q[W-2:0], fits};
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) begin
                run_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/freq_div_sched.sv
// Multi-channel Hz-to-divider converter: round-robin scheduling of one shared divider.
module freq_div_sched
    import freq_div_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int W        = W_DEF,
    parameter int CLK_HALF = CLK_HALF_DEF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [NCH-1:0]   REQ,
    input  logic [NCH*W-1:0] FREQ,
    output logic [NCH-1:0]   BUSY,
    output logic [NCH*W-1:0] DIV,
    output logic [NCH-1:0]   DIV_VALID,
    output logic [NCH-1:0]   DIV_ERR
);
    localparam int GW = (NCH > 1) ? $clog2(NCH) : 1;

    state_t           state_q, state_d;
    logic [NCH-1:0]   busy_q;
    logic [NCH*W-1:0] div_q;
    logic [NCH-1:0]   vld_q;
    logic [NCH-1:0]   err_q;
    logic [W-1:0]     freq_q [NCH];
    logic [GW-1:0]    last_grant_q;
    logic [GW-1:0]    grant_q;
    logic             zero_q;

    logic             any;
    logic [GW-1:0]    pick;
    int               idx;
    logic [W-1:0]     pick_freq;
    logic [W-1:0]     dividend;
    logic             load;
    logic             start;
    logic             finish;
    logic [NCH-1:0]   grant_oh;
    logic [NCH-1:0]   clr_mask;
    logic [W-1:0]     quotient;
    logic             div_done;

    // Round-robin search begins one past the most recent grant.
    always_comb begin
        any  = 1'b0;
        pick = '0;
        idx  = 0;
        for (int k = 1; k <= NCH; k++) begin
            idx = (int'(last_grant_q) + k) % NCH;
            if (!any && busy_q[idx]) begin
                any  = 1'b1;
                pick = GW'(idx);
            end
        end
    end

    // Adding half the divisor first turns the truncating divide into round-to-nearest.
    assign pick_freq = freq_q[pick];
    assign dividend  = W'(CLK_HALF) + (pick_freq >> 1);
    assign grant_oh  = NCH'(1) << grant_q;
    assign clr_mask  = finish ? grant_oh : '0;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        start   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (any) begin
                    load    = 1'b1;
                    start   = (pick_freq != '0);
                    state_d = (pick_freq == '0) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            busy_q       <= '0;
            div_q        <= '0;
            vld_q        <= '0;
            err_q        <= '0;
            last_grant_q <= GW'(NCH - 1);
            grant_q      <= '0;
            zero_q       <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                freq_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < NCH; i++) begin
                if (REQ[i] && !busy_q[i]) begin
                    freq_q[i] <= FREQ[i*W +: W];
                end
            end
            // New requests on other channels merge in on the same edge a completion clears.
            busy_q <= (busy_q | REQ) & ~clr_mask;
            vld_q  <= finish ? grant_oh : '0;
            err_q  <= (finish && zero_q) ? grant_oh : '0;
            if (load) begin
                grant_q      <= pick;
                last_grant_q <= pick;
                zero_q       <= (pick_freq == '0);
            end
            if (finish) begin
                div_q[grant_q*W +: W] <= zero_q ? '0 : quotient;
            end
        end
    end

    div_iter #(.W(W)) u_div (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .start    (start),
        .dividend (dividend),
        .divisor  (pick_freq),
        .quotient (quotient),
        .done     (div_done)
    );

    assign BUSY      = busy_q;
    assign DIV       = div_q;
    assign DIV_VALID = vld_q;
    assign DIV_ERR   = err_q;
endmodule
